// File: rtl/shared_pkg.sv
// Shared definitions for the SPI burst RAM: command encoding, default
// geometry and the depth-aware address increment.
package shared_pkg;

  typedef enum logic [1:0] {
    WR_ADDR = 2'd0,
    WR_DATA = 2'd1,
    RD_ADDR = 2'd2,
    RD_DATA = 2'd3
  } control_e;

  localparam int DEF_MEM_DEPTH = 256;
  localparam int DEF_ADDR_SIZE = 8;
  localparam int DEF_MEM_WIDTH = 8;

  // Next address, wrapping at the last real word rather than at the
  // top of the address space so non-power-of-two depths stay dense.
  function automatic int unsigned wrap_inc(input int unsigned addr,
                                           input int unsigned depth);
    return (addr >= depth - 1) ? 0 : addr + 1;
  endfunction

endpackage

// File: rtl/spi_sp_ram_core.sv
// Bare single-port RAM: synchronous write, registered read, no reset on
// the array or the read register.
module spi_sp_ram_core #(
  parameter int MEM_DEPTH = 256,
  parameter int MEM_WIDTH = 8,
  parameter int IDX_W     = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [IDX_W-1:0]     addr,
  input  logic [MEM_WIDTH-1:0] wdata,
  output logic [MEM_WIDTH-1:0] rdata
);

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

  // Array write and read register share the single address port.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/spi_burst_ram.sv
// SPI-command driven RAM with burst addressing, tx back-pressure and
// sticky error flags. Wraps spi_sp_ram_core.
module spi_burst_ram
  import shared_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int MEM_WIDTH = DEF_MEM_WIDTH,
  parameter bit AUTO_INC  = 1'b1,
  localparam int PAYLOAD_W = (ADDR_SIZE > MEM_WIDTH) ? ADDR_SIZE : MEM_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PAYLOAD_W+1:0] rx_data,
  input  logic                 rx_valid,
  output logic [MEM_WIDTH-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 addr_err,
  output logic                 ovr_err
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_SIZE:0] DEPTH_L = (ADDR_SIZE+1)'(MEM_DEPTH);

  control_e               cmd;
  logic [PAYLOAD_W-1:0]   payload;
  logic [ADDR_SIZE-1:0]   wr_addr, rd_addr;
  logic                   wr_oor, rd_oor;
  logic                   wr_cmd, rd_cmd, accept;
  logic                   wr_go, rd_go, rd_mem, ovr;
  logic                   zero_q;
  logic [ADDR_SIZE-1:0]   sel_addr;
  logic [MEM_WIDTH-1:0]   ram_rdata;

  assign cmd     = control_e'(rx_data[PAYLOAD_W+1:PAYLOAD_W]);
  assign payload = rx_data[PAYLOAD_W-1:0];

  assign wr_oor = {1'b0, wr_addr} >= DEPTH_L;
  assign rd_oor = {1'b0, rd_addr} >= DEPTH_L;

  assign accept = tx_valid && tx_ready;
  assign wr_cmd = rx_valid && (cmd == WR_DATA);
  assign rd_cmd = rx_valid && (cmd == RD_DATA);
  assign wr_go  = wr_cmd && !wr_oor;
  // A read may start when nothing is pending or the pending word leaves now.
  assign rd_go  = rd_cmd && (!tx_valid || accept);
  assign rd_mem = rd_go && !rd_oor;
  assign ovr    = rd_cmd && tx_valid && !accept;

  // Only one data command per cycle, so the port address follows the command.
  assign sel_addr = wr_cmd ? wr_addr : rd_addr;

  spi_sp_ram_core #(
    .MEM_DEPTH (MEM_DEPTH),
    .MEM_WIDTH (MEM_WIDTH),
    .IDX_W     (IDX_W)
  ) u_core (
    .clk   (clk),
    .we    (wr_go),
    .re    (rd_mem),
    .addr  (sel_addr[IDX_W-1:0]),
    .wdata (payload[MEM_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

  // The RAM read register has no reset, so a zero mask covers both reset
  // and out-of-range reads.
  assign tx_data = zero_q ? '0 : ram_rdata;

  // Address registers: explicit loads and post-increment on in-range access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr <= '0;
      rd_addr <= '0;
    end else begin
      if (rx_valid && cmd == WR_ADDR)
        wr_addr <= payload[ADDR_SIZE-1:0];
      else if (wr_go && AUTO_INC)
        wr_addr <= ADDR_SIZE'(wrap_inc(32'(wr_addr), MEM_DEPTH));
      if (rx_valid && cmd == RD_ADDR)
        rd_addr <= payload[ADDR_SIZE-1:0];
      else if (rd_mem && AUTO_INC)
        rd_addr <= ADDR_SIZE'(wrap_inc(32'(rd_addr), MEM_DEPTH));
    end
  end

  // Read handshake and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_valid <= 1'b0;
      zero_q   <= 1'b1;
      addr_err <= 1'b0;
      ovr_err  <= 1'b0;
    end else begin
      if (rd_go) begin
        tx_valid <= 1'b1;
        zero_q   <= rd_oor;
      end else if (accept) begin
        tx_valid <= 1'b0;
      end
      if ((wr_cmd && wr_oor) || (rd_go && rd_oor)) addr_err <= 1'b1;
      if (ovr) ovr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_burst_ram.sv
// Bench for spi_burst_ram: two instances (AUTO_INC=1 and AUTO_INC=0, both
// 200 words deep), expected read data queued per instance and compared by
// a monitor on every accepted word.
module tb_spi_burst_ram;

  localparam logic [1:0] C_WA = 2'd0, C_WD = 2'd1, C_RA = 2'd2, C_RD = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] rx_data  [2];
  logic       rx_valid [2];
  logic       tx_ready [2];
  logic [7:0] tx_data  [2];
  logic       tx_valid [2];
  logic       addr_err [2];
  logic       ovr_err  [2];

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  spi_burst_ram #(.MEM_DEPTH(200), .ADDR_SIZE(8), .MEM_WIDTH(8), .AUTO_INC(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .addr_err(addr_err[0]), .ovr_err(ovr_err[0]));

  spi_burst_ram #(.MEM_DEPTH(200), .ADDR_SIZE(8), .MEM_WIDTH(8), .AUTO_INC(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .addr_err(addr_err[1]), .ovr_err(ovr_err[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one frame; the caller stays aligned just after the sampling edge.
  task automatic send(input int d, input logic [1:0] c, input logic [7:0] p);
    rx_data[d]  = {c, p};
    rx_valid[d] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d, input int n);
    rx_valid[d] = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every word accepted by the consumer must match the queue head.
  always @(negedge clk) begin
    if (!rst && tx_valid[0] && tx_ready[0]) begin
      if (exp_q0.size() == 0) check("a_unexpected_word", {24'd0, tx_data[0]}, 32'hFFFF_FFFF);
      else check("a_tx_data", {24'd0, tx_data[0]}, {24'd0, exp_q0.pop_front()});
    end
    if (!rst && tx_valid[1] && tx_ready[1]) begin
      if (exp_q1.size() == 0) check("b_unexpected_word", {24'd0, tx_data[1]}, 32'hFFFF_FFFF);
      else check("b_tx_data", {24'd0, tx_data[1]}, {24'd0, exp_q1.pop_front()});
    end
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rx_data[i]  = '0;
      rx_valid[i] = 1'b0;
      tx_ready[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    for (int i = 0; i < 2; i++) begin
      check("rst_tx_valid", {31'd0, tx_valid[i]}, 32'd0);
      check("rst_tx_data",  {24'd0, tx_data[i]},  32'd0);
      check("rst_addr_err", {31'd0, addr_err[i]}, 32'd0);
      check("rst_ovr_err",  {31'd0, ovr_err[i]},  32'd0);
    end

    // burst write/read with back-to-back reads
    send(0, C_WA, 8'h10);
    send(0, C_WD, 8'hA1);
    send(0, C_WD, 8'hB2);
    send(0, C_WD, 8'hC3);
    send(0, C_RA, 8'h10);
    exp_q0.push_back(8'hA1); send(0, C_RD, 8'h00);
    exp_q0.push_back(8'hB2); send(0, C_RD, 8'h00);
    exp_q0.push_back(8'hC3); send(0, C_RD, 8'h00);
    idle(0, 2);
    check("burst_ovr_err", {31'd0, ovr_err[0]}, 32'd0);
    check("burst_tx_valid_low", {31'd0, tx_valid[0]}, 32'd0);

    // wrap at MEM_DEPTH-1
    send(0, C_WA, 8'd199);
    send(0, C_WD, 8'h11);
    send(0, C_WD, 8'h22);
    idle(0, 1);
    check("wrap_addr_err", {31'd0, addr_err[0]}, 32'd0);
    send(0, C_RA, 8'd199);
    exp_q0.push_back(8'h11); send(0, C_RD, 8'h00);
    exp_q0.push_back(8'h22); send(0, C_RD, 8'h00);
    idle(0, 2);

    // out-of-range write and read
    send(0, C_WA, 8'd250);
    send(0, C_WD, 8'h55);
    check("oor_wr_addr_err", {31'd0, addr_err[0]}, 32'd1);
    tx_ready[0] = 1'b0;
    send(0, C_RA, 8'd250);
    send(0, C_RD, 8'h00);
    idle(0, 1);
    check("oor_rd_tx_valid", {31'd0, tx_valid[0]}, 32'd1);
    check("oor_rd_tx_data",  {24'd0, tx_data[0]},  32'd0);
    exp_q0.push_back(8'h00);
    tx_ready[0] = 1'b1;
    idle(0, 3);
    check("oor_addr_err_sticky", {31'd0, addr_err[0]}, 32'd1);
    send(0, C_RA, 8'h12);
    exp_q0.push_back(8'hC3); send(0, C_RD, 8'h00);
    idle(0, 2);

    // back-pressure and overrun
    send(0, C_WA, 8'h20);
    send(0, C_WD, 8'h31);
    send(0, C_WD, 8'h32);
    tx_ready[0] = 1'b0;
    send(0, C_RA, 8'h20);
    exp_q0.push_back(8'h31); send(0, C_RD, 8'h00);
    check("bp_ovr_before", {31'd0, ovr_err[0]}, 32'd0);
    idle(0, 1);
    send(0, C_RD, 8'h00);
    check("bp_ovr_err", {31'd0, ovr_err[0]}, 32'd1);
    idle(0, 2);
    check("bp_tx_valid_held", {31'd0, tx_valid[0]}, 32'd1);
    check("bp_tx_data_held",  {24'd0, tx_data[0]},  32'h31);
    tx_ready[0] = 1'b1;
    idle(0, 1);
    exp_q0.push_back(8'h32); send(0, C_RD, 8'h00);
    idle(0, 2);

    // reset while a read is pending
    tx_ready[0] = 1'b0;
    send(0, C_RA, 8'h10);
    send(0, C_RD, 8'h00);
    idle(0, 1);
    check("pre_rst_tx_valid", {31'd0, tx_valid[0]}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_tx_valid", {31'd0, tx_valid[0]}, 32'd0);
    check("mid_rst_tx_data",  {24'd0, tx_data[0]},  32'd0);
    check("mid_rst_addr_err", {31'd0, addr_err[0]}, 32'd0);
    check("mid_rst_ovr_err",  {31'd0, ovr_err[0]},  32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tx_ready[0] = 1'b1;
    exp_q0.push_back(8'h22); send(0, C_RD, 8'h00);
    send(0, C_WD, 8'h77);
    send(0, C_RA, 8'h00);
    exp_q0.push_back(8'h77); send(0, C_RD, 8'h00);
    send(0, C_RA, 8'h11);
    exp_q0.push_back(8'hB2); send(0, C_RD, 8'h00);
    idle(0, 2);

    // AUTO_INC=0: address holds
    send(1, C_WA, 8'd6);
    send(1, C_WD, 8'h66);
    send(1, C_WA, 8'd5);
    send(1, C_WD, 8'h01);
    send(1, C_WD, 8'h02);
    send(1, C_RA, 8'd5);
    exp_q1.push_back(8'h02); send(1, C_RD, 8'h00);
    exp_q1.push_back(8'h02); send(1, C_RD, 8'h00);
    send(1, C_RA, 8'd6);
    exp_q1.push_back(8'h66); send(1, C_RD, 8'h00);
    idle(1, 2);
    check("b_addr_err", {31'd0, addr_err[1]}, 32'd0);
    check("b_ovr_err",  {31'd0, ovr_err[1]},  32'd0);

    // drain: every expected word must have been seen
    for (int i = 0; i < 20 && (exp_q0.size() != 0 || exp_q1.size() != 0); i++) begin
      @(posedge clk);
      #1;
    end
    check("a_words_outstanding", exp_q0.size(), 32'd0);
    check("b_words_outstanding", exp_q1.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
